// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg: shared definitions for the I2S receive path.
//   DEF_DATA_W / DEF_SLOT_W / DEF_SYNC_STAGES : default widths and depths
//   LR_LEFT / LR_RIGHT                        : lrclk level of each channel
//   state_e                                   : slot-tracking FSM states
// ---------------------------------------------------------------------------
package i2s_pkg;

  localparam int DEF_DATA_W      = 24;
  localparam int DEF_SLOT_W      = 32;
  localparam int DEF_SYNC_STAGES = 2;

  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ALIGN,
    DELAY,
    SHIFT,
    PAD
  } state_e;

endpackage

// File: rtl/i2s_rx_if.sv
// ---------------------------------------------------------------------------
// i2s_rx_if: stereo sample stream, valid/ready.
//   out_left / out_right : sample pair, stable while out_valid is high
//   out_valid            : pair available (driven by the receiver)
//   out_ready            : consumer accepts when out_valid && out_ready
// master = producing side (i2s_rx), slave = consuming side.
// ---------------------------------------------------------------------------
interface i2s_rx_if
  import i2s_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [DATA_W-1:0] out_left;
  logic [DATA_W-1:0] out_right;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_left,
    output out_right,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_left,
    input  out_right,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/i2s_edge_sync.sv
// ---------------------------------------------------------------------------
// i2s_edge_sync: brings the asynchronous codec-side bclk/lrclk/sdata into the
// system clock domain and flags rising edges of bclk.
//   clock, reset : system clock, synchronous active-high reset
//   bclk, lrclk, sdata : asynchronous codec signals
//   bclk_rise    : one-cycle pulse on each synchronized bclk rising edge
//   lrclk_s      : synchronized lrclk, aligned with bclk_rise
//   sdata_s      : synchronized sdata, aligned with bclk_rise
// All three inputs see the same number of stages, so lrclk_s/sdata_s in the
// bclk_rise cycle are the values that were present at the bclk edge.
// ---------------------------------------------------------------------------
module i2s_edge_sync
  import i2s_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  input  logic bclk,
  input  logic lrclk,
  input  logic sdata,
  output logic bclk_rise,
  output logic lrclk_s,
  output logic sdata_s
);

  logic [SYNC_STAGES-1:0] bclk_sr_q;
  logic [SYNC_STAGES-1:0] lrclk_sr_q;
  logic [SYNC_STAGES-1:0] sdata_sr_q;
  logic                   bclk_d_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      bclk_sr_q  <= '0;
      lrclk_sr_q <= '0;
      sdata_sr_q <= '0;
      bclk_d_q   <= 1'b0;
    end else begin
      bclk_sr_q[0]  <= bclk;
      lrclk_sr_q[0] <= lrclk;
      sdata_sr_q[0] <= sdata;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        bclk_sr_q[i]  <= bclk_sr_q[i-1];
        lrclk_sr_q[i] <= lrclk_sr_q[i-1];
        sdata_sr_q[i] <= sdata_sr_q[i-1];
      end
      bclk_d_q <= bclk_sr_q[SYNC_STAGES-1];
    end
  end

  assign lrclk_s   = lrclk_sr_q[SYNC_STAGES-1];
  assign sdata_s   = sdata_sr_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_sr_q[SYNC_STAGES-1] && !bclk_d_q;

endmodule

// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx: I2S bit-clock-slave receiver. Deserializes DATA_W-bit MSB-first
// left/right words from sdata and presents one stereo pair per lrclk frame.
//   clock, reset  : 100 MHz system clock, synchronous active-high reset
//   bclk, lrclk   : I2S bit clock / word select (observed only), async
//   sdata         : I2S serial data, async
//   out_if        : out_left/out_right/out_valid/out_ready pair stream
//   overrun       : sticky, a completed pair was dropped under backpressure
//   frame_err     : sticky, a slot ended before DATA_W bits were captured
//   clear_flags   : clears overrun/frame_err (a same-cycle set wins)
// ---------------------------------------------------------------------------
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SLOT_W      = DEF_SLOT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bclk,
  input  logic       lrclk,
  input  logic       sdata,
  i2s_rx_if.master   out_if,
  output logic       overrun,
  output logic       frame_err,
  input  logic       clear_flags
);

  localparam int CNT_W = $clog2(SLOT_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_W);

  logic bclk_rise;
  logic lrclk_s;
  logic sdata_s;

  i2s_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clock     (clock),
    .reset     (reset),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .sdata     (sdata),
    .bclk_rise (bclk_rise),
    .lrclk_s   (lrclk_s),
    .sdata_s   (sdata_s)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-2:0] shift_q, shift_d;     // bits received so far, LSB newest
  logic              chan_q, chan_d;
  logic              lr_prev_q, lr_prev_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d;
  logic              hold_l_vld_q, hold_l_vld_d;
  logic [DATA_W-1:0] out_left_q, out_left_d;
  logic [DATA_W-1:0] out_right_q, out_right_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;

  logic              lr_edge;
  logic [DATA_W-1:0] word;
  logic              complete;
  logic              ferr_set;
  logic              ovr_set;

  assign lr_edge = bclk_rise && (lrclk_s != lr_prev_q);
  // Word as it stands once the current bit is shifted in.
  assign word    = {shift_q, sdata_s};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ALIGN;
      cnt_q        <= '0;
      shift_q      <= '0;
      chan_q       <= LR_LEFT;
      lr_prev_q    <= 1'b0;
      hold_l_q     <= '0;
      hold_l_vld_q <= 1'b0;
      out_left_q   <= '0;
      out_right_q  <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      chan_q       <= chan_d;
      lr_prev_q    <= lr_prev_d;
      hold_l_q     <= hold_l_d;
      hold_l_vld_q <= hold_l_vld_d;
      out_left_q   <= out_left_d;
      out_right_q  <= out_right_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Slot tracking and deserialization; everything advances on bclk_rise only.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    chan_d       = chan_q;
    lr_prev_d    = lr_prev_q;
    hold_l_d     = hold_l_q;
    hold_l_vld_d = hold_l_vld_q;
    complete     = 1'b0;
    ferr_set     = 1'b0;

    if (bclk_rise) begin
      lr_prev_d = lrclk_s;
      // A new left slot starts a new frame: any earlier left word is stale.
      if (lr_edge && lrclk_s == LR_LEFT) hold_l_vld_d = 1'b0;

      unique case (state_q)
        ALIGN: begin
          if (lr_edge && lrclk_s == LR_LEFT) begin
            state_d = DELAY;
            chan_d  = LR_LEFT;
          end
        end
        DELAY, SHIFT: begin
          if (lr_edge) begin
            // Slot cut short: drop the partial word and follow the new slot.
            ferr_set = 1'b1;
            state_d  = DELAY;
            chan_d   = lrclk_s;
            if (lrclk_s == LR_RIGHT) hold_l_vld_d = 1'b0;
          end else if (state_q == DELAY) begin
            shift_d    = '0;
            shift_d[0] = sdata_s;
            cnt_d      = CNT_W'(1);
            state_d    = SHIFT;
          end else begin
            shift_d = word[DATA_W-2:0];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_d = PAD;
              if (chan_q == LR_LEFT) begin
                hold_l_d     = word;
                hold_l_vld_d = 1'b1;
              end else if (hold_l_vld_q) begin
                complete     = 1'b1;
                hold_l_vld_d = 1'b0;
              end
            end
          end
        end
        PAD: begin
          if (lr_edge) begin
            state_d = DELAY;
            chan_d  = lrclk_s;
          end else if (cnt_q != CNT_SLOT) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ALIGN;
      endcase
    end
  end

  // Output register, handshake and sticky flags.
  always_comb begin
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    out_valid_d = out_valid_q;
    ovr_set     = 1'b0;

    if (complete && (!out_valid_q || out_if.out_ready)) begin
      out_left_d  = hold_l_q;
      out_right_d = word;
      out_valid_d = 1'b1;
    end else begin
      if (complete) ovr_set = 1'b1;
      if (out_valid_q && out_if.out_ready) out_valid_d = 1'b0;
    end

    overrun_d   = ovr_set  ? 1'b1 : (clear_flags ? 1'b0 : overrun_q);
    frame_err_d = ferr_set ? 1'b1 : (clear_flags ? 1'b0 : frame_err_q);
  end

  assign out_if.out_left  = out_left_q;
  assign out_if.out_right = out_right_q;
  assign out_if.out_valid = out_valid_q;
  assign overrun          = overrun_q;
  assign frame_err        = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx: directed bench for i2s_rx. bclk runs at 1/32 of the system
// clock; every bit is a 16-cycle low phase then a 16-cycle high phase, with
// lrclk/sdata changing on the falling bclk edge as in I2S.
// ---------------------------------------------------------------------------
module tb_i2s_rx;

  logic clock = 1'b0;
  logic reset;
  logic bclk;
  logic lrclk;
  logic sdata;
  logic overrun;
  logic frame_err;
  logic clear_flags;
  logic pad;

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  i2s_rx_if #(.DATA_W(24)) sif ();

  i2s_rx #(
    .DATA_W      (24),
    .SLOT_W      (32),
    .SYNC_STAGES (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .out_if      (sif.master),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .clear_flags (clear_flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One bclk period. hit: pulse out_ready so the accept lands on the same
  // clock as the pair completion from this rise (2 sync stages + 1).
  // rpulse: one-cycle reset in the middle of the low phase.
  task automatic send_bit(input logic lr, input logic d, input bit hit, input bit rpulse);
    @(negedge clock);
    bclk  = 1'b0;
    lrclk = lr;
    sdata = d;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (rpulse) reset = (i == 4);
    end
    @(negedge clock);
    bclk = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (hit && i == 1) begin
        chk("sim_pre_valid", {31'd0, sif.out_valid}, 32'd1);
        chk("sim_pre_left",  {8'd0, sif.out_left},   32'h000005);
        sif.out_ready = 1'b1;
      end else if (hit && i == 2) begin
        sif.out_ready = 1'b0;
        chk("sim_valid",   {31'd0, sif.out_valid}, 32'd1);
        chk("sim_left",    {8'd0, sif.out_left},   32'h000007);
        chk("sim_right",   {8'd0, sif.out_right},  32'h000008);
        chk("sim_overrun", {31'd0, overrun},       32'd0);
      end
    end
  endtask

  // Rise 0 carries the previous slot's trailing bit, rises 1..24 the word.
  task automatic send_slot(input logic lr, input logic [23:0] w, input int nrise,
                           input int hit_k, input int rst_k);
    for (int k = 0; k < nrise; k++)
      send_bit(lr, (k >= 1 && k <= 24) ? w[24-k] : pad, k == hit_k, k == rst_k);
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int lrises,
                            input int hit_k, input int rst_k);
    send_slot(1'b0, l, lrises, -1, -1);
    send_slot(1'b1, r, 32, hit_k, rst_k);
  endtask

  task automatic check_pair(input string tag, input logic [23:0] l, input logic [23:0] r);
    chk({tag, "_valid"}, {31'd0, sif.out_valid}, 32'd1);
    chk({tag, "_left"},  {8'd0, sif.out_left},   {8'd0, l});
    chk({tag, "_right"}, {8'd0, sif.out_right},  {8'd0, r});
  endtask

  task automatic do_accept(input string tag);
    @(negedge clock);
    sif.out_ready = 1'b1;
    @(negedge clock);
    sif.out_ready = 1'b0;
    chk(tag, {31'd0, sif.out_valid}, 32'd0);
  endtask

  task automatic pulse_clear();
    @(negedge clock);
    clear_flags = 1'b1;
    @(negedge clock);
    clear_flags = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bclk          = 1'b0;
    lrclk         = 1'b0;
    sdata         = 1'b0;
    clear_flags   = 1'b0;
    pad           = 1'b1;
    sif.out_ready = 1'b0;
    repeat (4) @(negedge clock);

    // Reset state
    chk("rst_left",      {8'd0, sif.out_left},   32'd0);
    chk("rst_right",     {8'd0, sif.out_right},  32'd0);
    chk("rst_valid",     {31'd0, sif.out_valid}, 32'd0);
    chk("rst_overrun",   {31'd0, overrun},       32'd0);
    chk("rst_frame_err", {31'd0, frame_err},     32'd0);

    // Start-up: reset released in the middle of a right slot
    for (int k = 0; k < 10; k++) send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    for (int k = 10; k < 32; k++) send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    chk("align_no_valid", {31'd0, sif.out_valid}, 32'd0);

    // Normal frame
    send_frame(24'h123456, 24'hABCDEF, 32, -1, -1);
    check_pair("norm", 24'h123456, 24'hABCDEF);
    chk("norm_overrun",   {31'd0, overrun},   32'd0);
    chk("norm_frame_err", {31'd0, frame_err}, 32'd0);
    do_accept("norm_accept");

    send_frame(24'h800001, 24'h7FFFFE, 32, -1, -1);
    check_pair("norm2", 24'h800001, 24'h7FFFFE);
    do_accept("norm2_accept");

    // Backpressure over two frames
    send_frame(24'h000001, 24'h000002, 32, -1, -1);
    check_pair("bp1", 24'h000001, 24'h000002);
    chk("bp1_overrun", {31'd0, overrun}, 32'd0);
    send_frame(24'h000003, 24'h000004, 32, -1, -1);
    check_pair("bp2", 24'h000001, 24'h000002);
    chk("bp2_overrun", {31'd0, overrun}, 32'd1);
    do_accept("bp_accept");
    chk("bp_overrun_sticky", {31'd0, overrun}, 32'd1);
    pulse_clear();
    chk("bp_overrun_clr", {31'd0, overrun}, 32'd0);

    // Accept coinciding with completion
    send_frame(24'h000005, 24'h000006, 32, -1, -1);
    check_pair("sim_first", 24'h000005, 24'h000006);
    send_frame(24'h000007, 24'h000008, 32, 24, -1);
    chk("sim_overrun_end", {31'd0, overrun}, 32'd0);
    do_accept("sim_accept");

    // Short left slot (20 bits)
    send_frame(24'hFEDCBA, 24'h135790, 21, -1, -1);
    chk("short_frame_err", {31'd0, frame_err},     32'd1);
    chk("short_no_valid",  {31'd0, sif.out_valid}, 32'd0);
    send_frame(24'h2468AC, 24'h55AA33, 32, -1, -1);
    check_pair("after_short", 24'h2468AC, 24'h55AA33);
    chk("short_err_sticky", {31'd0, frame_err}, 32'd1);
    pulse_clear();
    chk("short_err_clr", {31'd0, frame_err}, 32'd0);

    // Reset during right-slot bit 10, pair left pending in the output
    send_frame(24'h111111, 24'h222222, 32, -1, 11);
    chk("rmid_left",  {8'd0, sif.out_left},   32'd0);
    chk("rmid_right", {8'd0, sif.out_right},  32'd0);
    chk("rmid_valid", {31'd0, sif.out_valid}, 32'd0);
    send_frame(24'hC0FFEE, 24'h0BEEF0, 32, -1, -1);
    check_pair("after_rst", 24'hC0FFEE, 24'h0BEEF0);
    chk("after_rst_flags", {30'd0, overrun, frame_err}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Captures the codec ADC serial stream (ac_adc_sdata) in I2S format into parallel 24-bit left/right samples.
- Acts as the receive-side counterpart of the audio transmit path. It is a bit-clock slave: BCLK and LRCLK are driven by the transmit controller, and this block only observes them.
- Delivers one stereo pair per LRCLK frame on a valid/ready interface to the consuming logic (mixer/display), running on the 100 MHz system clock.

Parameters:
- DATA_W, 24, bits captured per channel, MSB first.
- SLOT_W, 32, BCLK periods per channel slot; bits after DATA_W are ignored.
- SYNC_STAGES, 2, flip-flop stages on the bclk/lrclk/sdata inputs.

Ports:
- clock  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- bclk  in  1  I2S bit clock, asynchronous; period must be at least 8 clock cycles.
- lrclk  in  1  I2S word select: 0 = left, 1 = right. Asynchronous.
- sdata  in  1  I2S serial data (ac_adc_sdata). Asynchronous.
- out_left  out  DATA_W  captured left sample.
- out_right  out  DATA_W  captured right sample.
- out_valid  out  1  stereo pair available.
- out_ready  in  1  consumer accepts the pair when out_valid && out_ready.
- overrun  out  1  sticky: a completed pair was dropped.
- frame_err  out  1  sticky: a slot ended before DATA_W bits were captured.
- clear_flags  in  1  synchronous clear of overrun and frame_err.

Behaviour:
- Reset: out_left=0, out_right=0, out_valid=0, overrun=0, frame_err=0, FSM=ALIGN, all shift and sync registers cleared.
- Input path:
  - bclk, lrclk and sdata each pass through SYNC_STAGES flops with identical delay.
  - rise = bclk_s && !bclk_d is a one-cycle pulse.
  - All sampling happens only on rise cycles; sdata and lrclk use their synchronized values in that cycle.
- lr_edge: asserted on a rise where lrclk_s differs from the lrclk value latched on the previous rise.
- I2S timing:
  - The MSB of a slot appears on the first rise after the lr_edge rise (one-bit delay).
  - The channel for the slot is the lrclk value latched at the edge.
- FSM states: ALIGN, DELAY, SHIFT, PAD.
  - ALIGN: ignore data. On a lr_edge to lrclk=0 (start of left slot), go to DELAY. Start-up mid-frame therefore never emits a partial pair.
  - DELAY: on the next rise, load bit 0 as MSB, set bit count to 1, go to SHIFT.
  - SHIFT: on each rise, shift sdata in (MSB first) and increment the count. When count reaches DATA_W, commit the word to hold_l (if left) or hold_r (if right), then go to PAD.
    - If lr_edge occurs in SHIFT, set frame_err, discard the partial word and go to DELAY for the new channel.
    - If that new channel is right, also discard any pending hold_l.
  - PAD: ignore bits. On lr_edge go to DELAY.
    - If lrclk becomes 1 without a committed left word for this frame, the right slot is captured but not emitted.
- Pair completion:
  - Occurs on the cycle the right word commits while a left word from the same frame is held.
  - On the next cycle, out_left/out_right load the pair and out_valid=1. Latency is 1 cycle after the final right-bit rise.
- Handshake:
  - out_valid stays high and the outputs stay stable until out_valid && out_ready.
  - On an accept with no simultaneous completion, out_valid drops the next cycle.
- Backpressure:
  - If a pair completes while out_valid=1 and out_ready=0, the new pair is dropped, the old outputs are held and overrun is set.
  - If accept and completion fall in the same cycle, the new pair loads, out_valid stays 1 and overrun is not set.
- Sticky flags: overrun and frame_err hold until reset or clear_flags. If clear_flags coincides with a new set event, the set wins.
- Reset mid-frame: returns to ALIGN. The next pair is emitted only after a full left+right frame following the next left-slot edge.
- Arithmetic: bit count is $clog2(SLOT_W+1) wide. Counts saturate in PAD and never wrap.

Decomposition:
- Package i2s_pkg: DATA_W/SLOT_W defaults, the state enum (ALIGN, DELAY, SHIFT, PAD), and the LR_LEFT=0 / LR_RIGHT=1 constants.
- Sub-module i2s_edge_sync: SYNC_STAGES synchronizer for bclk/lrclk/sdata plus rise detection. It outputs bclk_rise, lrclk_s and sdata_s, and is reusable by other codec-side blocks.

Test Plan:
- Normal frame: BCLK at 1/32 of clock, frames L=0x123456, R=0xABCDEF, pad bits 1 -> one out_valid per frame, out_left=0x123456, out_right=0xABCDEF, flags 0.
- Start-up alignment: release reset in the middle of a right slot -> no out_valid until the first complete left+right pair; that first pair is correct.
- Backpressure: out_ready=0 across two frames (L=0x000001/R=0x000002, then L=0x000003/R=0x000004) -> outputs hold 0x000001/0x000002, overrun=1. Then out_ready=1 -> out_valid drops, overrun stays 1 until clear_flags.
- Simultaneous accept and completion: assert out_ready exactly on the completion cycle of the next pair -> new pair loads, out_valid stays 1, overrun=0.
- Short slot: toggle lrclk after 20 bits of the left slot -> frame_err=1, no pair emitted for that frame, the following full frame is emitted correctly.
- Reset mid-SHIFT: assert reset for 1 cycle during right-slot bit 10 -> all outputs 0, ALIGN re-entered, the next full frame is emitted correctly.
